// File: rtl/text_banner_gen_pkg.sv
// Shared glyph constants for the banner renderer and its font ROM interface.
package text_banner_gen_pkg;

  localparam int unsigned GLYPH_W = 8;
  localparam int unsigned GLYPH_H = 16;
  localparam int unsigned ROM_AW  = 6;

  localparam logic [1:0] CODE_I = 2'd1;
  localparam logic [1:0] CODE_S = 2'd2;
  localparam logic [1:0] CODE_A = 2'd3;

endpackage

// File: rtl/text_banner_gen_blink_timer.sv
// Frame counter that toggles banner visibility every BlinkFrames frames.
module text_banner_gen_blink_timer #(
  parameter int unsigned BlinkFrames = 30
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic frame_start_i,
  input  logic blink_en_i,
  output logic visible_o
);

  localparam int unsigned CntW = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BlinkFrames - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            visible_q, visible_d;

  always_comb begin
    cnt_d     = cnt_q;
    visible_d = visible_q;
    if (tick_i) begin
      if (!blink_en_i) begin
        // Disabling blink forces the banner back on immediately.
        cnt_d     = '0;
        visible_d = 1'b1;
      end else if (frame_start_i) begin
        if (cnt_q == CntMax) begin
          cnt_d     = '0;
          visible_d = ~visible_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      visible_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      visible_q <= visible_d;
    end
  end

  assign visible_o = visible_q;

endmodule

// File: rtl/text_banner_gen.sv
// Two-stage pixel pipeline drawing the "ISA" banner from the glyph font ROM,
// with hsync/vsync delayed to stay aligned with the pixel stream.
module text_banner_gen
  import text_banner_gen_pkg::*;
#(
  parameter int unsigned X0           = 16,
  parameter int unsigned Y0           = 32,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h008
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              blink_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              text_on,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int unsigned BoxW = (3 * GLYPH_W) << SCALE_LOG2;
  localparam int unsigned BoxH = GLYPH_H << SCALE_LOG2;
  localparam logic [10:0] XLo  = 11'(X0);
  localparam logic [10:0] XHi  = 11'(X0 + BoxW);
  localparam logic [10:0] YLo  = 11'(Y0);
  localparam logic [10:0] YHi  = 11'(Y0 + BoxH);

  logic              in_box;
  logic [9:0]        dx, dy;
  logic [4:0]        rx;
  logic [3:0]        ry;
  logic [ROM_AW-1:0] rom_addr_d;
  logic [2:0]        col_d;
  logic              frame_start;
  logic              visible;
  logic              text_on_next;
  logic [11:0]       rgb_next;

  // Stage-1 and stage-2 pipeline registers.
  logic [ROM_AW-1:0] rom_addr_q;
  logic [2:0]        col_q;
  logic              in_box_q, video_on_q, hsync_q, vsync_q;
  logic              text_on_q, hsync_out_q, vsync_out_q;
  logic [11:0]       rgb_q;

  always_comb begin
    in_box = ({1'b0, pixel_x} >= XLo) && ({1'b0, pixel_x} < XHi) &&
             ({1'b0, pixel_y} >= YLo) && ({1'b0, pixel_y} < YHi);
    dx     = pixel_x - XLo[9:0];
    dy     = pixel_y - YLo[9:0];
    rx     = 5'(dx >> SCALE_LOG2);
    ry     = 4'(dy >> SCALE_LOG2);
    // Out-of-box pixels point at glyph 0, which the ROM keeps blank.
    rom_addr_d = in_box ? {rx[4:3] + CODE_I, ry} : '0;
    col_d      = in_box ? rx[2:0] : 3'd0;
  end

  assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

  text_banner_gen_blink_timer #(
    .BlinkFrames (BLINK_FRAMES)
  ) u_blink_timer (
    .clk_i         (clk),
    .reset_i       (reset),
    .tick_i        (pixel_tick),
    .frame_start_i (frame_start),
    .blink_en_i    (blink_en),
    .visible_o     (visible)
  );

  // Glyph bit 7 is the leftmost pixel of a row.
  always_comb begin
    text_on_next = in_box_q & video_on_q & visible & rom_data[3'd7 - col_q];
    rgb_next     = text_on_next ? FG_COLOR : (video_on_q ? BG_COLOR : 12'h000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q  <= '0;
      col_q       <= '0;
      in_box_q    <= 1'b0;
      video_on_q  <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      text_on_q   <= 1'b0;
      rgb_q       <= '0;
      hsync_out_q <= 1'b0;
      vsync_out_q <= 1'b0;
    end else if (pixel_tick) begin
      rom_addr_q  <= rom_addr_d;
      col_q       <= col_d;
      in_box_q    <= in_box;
      video_on_q  <= video_on;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      text_on_q   <= text_on_next;
      rgb_q       <= rgb_next;
      hsync_out_q <= hsync_q;
      vsync_out_q <= vsync_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign text_on   = text_on_q;
  assign rgb       = rgb_q;
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;

endmodule

// File: tb/tb_text_banner_gen.sv
// Scoreboard bench: two banner instances (1x and 2x scale) driven in parallel
// against a coordinate-level reference model with an attached font ROM.
`timescale 1ns/1ps
module tb_text_banner_gen;

  localparam int X0  = 16;
  localparam int Y0  = 32;
  localparam int S0  = 0;
  localparam int S1  = 1;
  localparam int BF0 = 2;
  localparam int BF1 = 3;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h008;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_tick = 1'b0;
  logic       video_on = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       blink_en = 1'b0;

  logic [5:0]  rom_addr0, rom_addr1;
  logic [7:0]  rom_data0, rom_data1;
  logic        text_on0, text_on1;
  logic [11:0] rgb0, rgb1;
  logic        hsync_out0, hsync_out1, vsync_out0, vsync_out1;

  logic [7:0] rom_mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        t0, t1;
    logic [11:0] rgb0, rgb1;
    logic        hs, vs;
  } out_t;
  typedef struct {
    logic [5:0] a0, a1;
  } addr_t;

  out_t  out_q[$];
  addr_t addr_q[$];

  int cnt0, cnt1;
  bit vis0, vis1;

  always #5 clk = ~clk;

  text_banner_gen #(.X0(X0), .Y0(Y0), .SCALE_LOG2(S0), .BLINK_FRAMES(BF0),
                    .FG_COLOR(FG), .BG_COLOR(BG)) dut0 (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .blink_en(blink_en), .rom_addr(rom_addr0), .rom_data(rom_data0), .text_on(text_on0),
    .rgb(rgb0), .hsync_out(hsync_out0), .vsync_out(vsync_out0)
  );

  text_banner_gen #(.X0(X0), .Y0(Y0), .SCALE_LOG2(S1), .BLINK_FRAMES(BF1),
                    .FG_COLOR(FG), .BG_COLOR(BG)) dut1 (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .blink_en(blink_en), .rom_addr(rom_addr1), .rom_data(rom_data1), .text_on(text_on1),
    .rgb(rgb1), .hsync_out(hsync_out1), .vsync_out(vsync_out1)
  );

  // Font ROM with a registered address, one per instance.
  always @(posedge clk) begin
    rom_data0 <= rom_mem[rom_addr0];
    rom_data1 <= rom_mem[rom_addr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic missing(input string name);
    n_checks++;
    $display("FAIL %s: no expected entry queued at %0t", name, $time);
  endtask

  // Which glyph pixel a screen coordinate lands on, and whether it is lit.
  function automatic void glyph_px(input int s, input int x, input int y,
                                   output logic [5:0] addr, output logic lit);
    int gx, gy, code;
    if (x >= X0 && x < X0 + (24 << s) && y >= Y0 && y < Y0 + (16 << s)) begin
      gx   = (x - X0) >> s;
      gy   = (y - Y0) >> s;
      code = gx / 8 + 1;
      addr = 6'(code * 16 + gy);
      lit  = rom_mem[addr][7 - (gx % 8)];
    end else begin
      addr = 6'd0;
      lit  = 1'b0;
    end
  endfunction

  task automatic blink_step(input int bf, input bit en, input bit fs,
                            inout int cnt, inout bit vis);
    if (!en) begin
      cnt = 0;
      vis = 1'b1;
    end else if (fs) begin
      if (cnt == bf - 1) begin
        cnt = 0;
        vis = !vis;
      end else begin
        cnt++;
      end
    end
  endtask

  function automatic out_t zero_out();
    out_t e;
    e.t0 = 0; e.t1 = 0; e.rgb0 = '0; e.rgb1 = '0; e.hs = 0; e.vs = 0;
    return e;
  endfunction

  // One pixel tick, then three idle clocks.
  task automatic issue(input int x, input int y, input bit vid, input bit hs,
                       input bit vs, input bit en);
    logic [5:0] a0, a1;
    logic       l0, l1;
    out_t       e;
    addr_t      ea;
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = vid;
    hsync_in = hs;
    vsync_in = vs;
    blink_en = en;
    blink_step(BF0, en, (x == 0 && y == 0), cnt0, vis0);
    blink_step(BF1, en, (x == 0 && y == 0), cnt1, vis1);
    glyph_px(S0, x, y, a0, l0);
    glyph_px(S1, x, y, a1, l1);
    ea.a0  = a0;
    ea.a1  = a1;
    e.t0   = l0 & vid & vis0;
    e.t1   = l1 & vid & vis1;
    e.rgb0 = e.t0 ? FG : (vid ? BG : 12'h000);
    e.rgb1 = e.t1 ? FG : (vid ? BG : 12'h000);
    e.hs   = hs;
    e.vs   = vs;
    addr_q.push_back(ea);
    out_q.push_back(e);
    pixel_tick = 1'b1;
    @(negedge clk);
    pixel_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_rom_addr0", 32'(rom_addr0), 32'h0);
    check("rst_rom_addr1", 32'(rom_addr1), 32'h0);
    check("rst_text_on0", 32'(text_on0), 32'h0);
    check("rst_text_on1", 32'(text_on1), 32'h0);
    check("rst_rgb0", 32'(rgb0), 32'h0);
    check("rst_rgb1", 32'(rgb1), 32'h0);
    check("rst_hsync_out", 32'({hsync_out0, hsync_out1}), 32'h0);
    check("rst_vsync_out", 32'({vsync_out0, vsync_out1}), 32'h0);
    cnt0 = 0; cnt1 = 0; vis0 = 1'b1; vis1 = 1'b1;
    addr_q.delete();
    out_q.delete();
    out_q.push_back(zero_out());
  endtask

  // Monitor: every tick the DUT presents a new address and a new pixel.
  always @(posedge clk) begin
    if (pixel_tick && !reset) begin
      addr_t ea;
      out_t  e;
      #1;
      if (addr_q.size() == 0) missing("rom_addr");
      else begin
        ea = addr_q.pop_front();
        check("rom_addr0", 32'(rom_addr0), 32'(ea.a0));
        check("rom_addr1", 32'(rom_addr1), 32'(ea.a1));
      end
      if (out_q.size() == 0) missing("pixel_out");
      else begin
        e = out_q.pop_front();
        check("text_on0", 32'(text_on0), 32'(e.t0));
        check("text_on1", 32'(text_on1), 32'(e.t1));
        check("rgb0", 32'(rgb0), 32'(e.rgb0));
        check("rgb1", 32'(rgb1), 32'(e.rgb1));
        check("hsync_out", 32'({hsync_out0, hsync_out1}), 32'({e.hs, e.hs}));
        check("vsync_out", 32'({vsync_out0, vsync_out1}), 32'({e.vs, e.vs}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x, y;
    for (int a = 0; a < 64; a++) rom_mem[a] = (a < 16) ? 8'h00 : 8'($urandom);
    rom_mem[6'h11] = 8'hFE;
    rom_mem[6'h32] = 8'h38;
    rom_mem[6'h25] = rom_mem[6'h25] | 8'h40;

    repeat (3) @(negedge clk);
    do_reset();

    // Directed points from the banner layout.
    issue(16, 33, 1, 0, 0, 0);
    check("addr_16_33", 32'(rom_addr0), 32'h11);
    issue(23, 33, 1, 0, 0, 0);
    check("lit_16_33", 32'({text_on0, rgb0}), 32'({1'b1, 12'hFFF}));
    issue(25, 37, 1, 0, 0, 0);
    check("dark_23_33", 32'({text_on0, rgb0}), 32'({1'b0, 12'h008}));
    issue(40, 33, 1, 0, 0, 0);
    check("addr_40_33", 32'(rom_addr0), 32'h00);
    issue(39, 34, 1, 0, 0, 0);
    check("addr_39_34", 32'(rom_addr0), 32'h32);
    issue(20, 33, 0, 0, 0, 0);
    issue(16, 32, 1, 0, 0, 0);
    check("rgb_video_off", 32'(rgb0), 32'h0);
    check("addr_x2_16_32", 32'(rom_addr1), 32'h10);
    issue(17, 33, 1, 0, 0, 0);
    check("addr_x2_17_33", 32'(rom_addr1), 32'h10);
    issue(63, 63, 1, 0, 0, 0);
    check("addr_x2_63_63", 32'(rom_addr1), 32'h3F);
    issue(64, 33, 1, 1, 1, 0);
    check("addr_x2_64_33", 32'(rom_addr1), 32'h00);
    issue(63, 64, 1, 0, 0, 0);

    // Blink: frame starts interleaved with a lit banner pixel.
    for (int k = 1; k <= 6; k++) begin
      issue(0, 0, 1, 0, 0, 1);
      issue(16, 33, 1, 0, 0, 1);
      issue(70, 70, 1, 0, 0, 1);
      if (k <= 4) check($sformatf("blink_fs%0d", k), 32'(text_on0),
                        32'((k == 2 || k == 3) ? 0 : 1));
    end
    issue(16, 33, 1, 0, 0, 0);
    issue(70, 70, 1, 0, 0, 0);
    check("blink_drop", 32'(text_on0), 32'h1);

    // Reset mid-banner, then an hsync pulse through the refilled pipeline.
    issue(16, 33, 1, 0, 0, 0);
    issue(17, 33, 1, 1, 0, 0);
    do_reset();
    issue(16, 33, 1, 1, 0, 0);
    check("hs_tick1", 32'(hsync_out0), 32'h0);
    issue(17, 33, 1, 0, 0, 0);
    check("hs_tick2", 32'(hsync_out0), 32'h1);
    issue(18, 33, 1, 0, 0, 0);
    check("hs_tick3", 32'(hsync_out0), 32'h0);

    // Randomized sweep around both banner boxes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        x = 0; y = 0;
      end else begin
        x = int'($urandom_range(0, 99));
        y = int'($urandom_range(20, 99));
      end
      issue(x, y, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) != 0));
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
